// File: rtl/alu_arbiter_pkg.sv
// Shared pipeline package.
// Holds the ALU opcode enumeration and the requester-id type used by the
// arbiter and by its ALU datapath, plus a small opcode legality helper.
package alu_arbiter_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_SLT  = 4'h2,
        ALU_SLTU = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_OR   = 4'h5,
        ALU_AND  = 4'h6,
        ALU_SLL  = 4'h7,
        ALU_SRL  = 4'h8,
        ALU_SRA  = 4'h9
    } alu_op_e;

    typedef enum logic {
        ReqId0 = 1'b0,
        ReqId1 = 1'b1
    } req_id_e;

    // Opcodes above ALU_SRA (0xA-0xF) are reserved.
    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= ALU_SRA;
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU.
// Ports:
//   operand_a_i, operand_b_i : 32-bit operands
//   alu_op_i                 : 4-bit opcode (alu_op_e)
//   alu_data_o               : result, 0 for reserved opcodes
//   alu_illegal_o            : 1 when alu_op_i is a reserved opcode
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    input  logic [3:0]      alu_op_i,
    output logic [XLEN-1:0] alu_data_o,
    output logic            alu_illegal_o
);

    logic [4:0] shamt;

    assign shamt = operand_b_i[4:0];

    always_comb begin
        alu_data_o    = '0;
        alu_illegal_o = !is_legal_op(alu_op_i);
        case (alu_op_i)
            ALU_ADD:  alu_data_o = operand_a_i + operand_b_i;
            ALU_SUB:  alu_data_o = operand_a_i - operand_b_i;
            ALU_SLT:  alu_data_o = {31'b0, $signed(operand_a_i) < $signed(operand_b_i)};
            ALU_SLTU: alu_data_o = {31'b0, operand_a_i < operand_b_i};
            ALU_XOR:  alu_data_o = operand_a_i ^ operand_b_i;
            ALU_OR:   alu_data_o = operand_a_i | operand_b_i;
            ALU_AND:  alu_data_o = operand_a_i & operand_b_i;
            ALU_SLL:  alu_data_o = operand_a_i << shamt;
            ALU_SRL:  alu_data_o = operand_a_i >> shamt;
            ALU_SRA:  alu_data_o = $unsigned($signed(operand_a_i) >>> shamt);
            default:  alu_data_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a single shared ALU.
// One operation is outstanding at a time: a granted request is computed
// combinationally, registered on the transfer edge, and held until the
// owning requester takes the response.
// Ports:
//   clk_i, rst_ni                 : clock, async active-low reset
//   reqN_valid_i / reqN_ready_o   : request handshake for requester N
//   reqN_a_i, reqN_b_i, reqN_op_i : operands and opcode for requester N
//   rspN_valid_o / rspN_ready_i   : response handshake for requester N
//   rsp_data_o, rsp_illegal_o     : registered result shared by both responses
//   grantN_cnt_o                  : saturating accepted-operation count
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [XLEN-1:0]  req0_a_i,
    input  logic [XLEN-1:0]  req0_b_i,
    input  logic [3:0]       req0_op_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [XLEN-1:0]  req1_a_i,
    input  logic [XLEN-1:0]  req1_b_i,
    input  logic [3:0]       req1_op_i,
    output logic             rsp0_valid_o,
    input  logic             rsp0_ready_i,
    output logic             rsp1_valid_o,
    input  logic             rsp1_ready_i,
    output logic [XLEN-1:0]  rsp_data_o,
    output logic             rsp_illegal_o,
    output logic [CNT_W-1:0] grant0_cnt_o,
    output logic [CNT_W-1:0] grant1_cnt_o
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StHold = 1'b1;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [0:0]      state_q, state_d;
    req_id_e         last_q, last_d;
    req_id_e         owner_q, owner_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    req_id_e         gnt_id;
    logic            gnt_valid;
    logic            xfer;
    logic            rsp_hs;
    logic [XLEN-1:0] alu_a, alu_b, alu_data;
    logic [3:0]      alu_op;
    logic            alu_illegal;

    // Round-robin pick: on contention the requester not granted last wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = ReqId0;
        if (req0_valid_i && req1_valid_i) begin
            gnt_valid = 1'b1;
            gnt_id    = (last_q == ReqId0) ? ReqId1 : ReqId0;
        end else if (req0_valid_i) begin
            gnt_valid = 1'b1;
            gnt_id    = ReqId0;
        end else if (req1_valid_i) begin
            gnt_valid = 1'b1;
            gnt_id    = ReqId1;
        end
    end

    // rst_ni gates ready so nothing is accepted while reset is held.
    assign xfer         = rst_ni && (state_q == StIdle) && gnt_valid;
    assign req0_ready_o = xfer && (gnt_id == ReqId0);
    assign req1_ready_o = xfer && (gnt_id == ReqId1);

    assign rsp0_valid_o = (state_q == StHold) && (owner_q == ReqId0);
    assign rsp1_valid_o = (state_q == StHold) && (owner_q == ReqId1);
    assign rsp_hs       = (rsp0_valid_o && rsp0_ready_i) || (rsp1_valid_o && rsp1_ready_i);

    // Grant mux feeding the shared ALU.
    assign alu_a  = (gnt_id == ReqId1) ? req1_a_i  : req0_a_i;
    assign alu_b  = (gnt_id == ReqId1) ? req1_b_i  : req0_b_i;
    assign alu_op = (gnt_id == ReqId1) ? req1_op_i : req0_op_i;

    alu_arbiter_alu u_alu (
        .operand_a_i   (alu_a),
        .operand_b_i   (alu_b),
        .alu_op_i      (alu_op),
        .alu_data_o    (alu_data),
        .alu_illegal_o (alu_illegal)
    );

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        data_d    = data_q;
        illegal_d = illegal_q;
        cnt0_d    = cnt0_q;
        cnt1_d    = cnt1_q;
        if (xfer) begin
            state_d   = StHold;
            last_d    = gnt_id;
            owner_d   = gnt_id;
            data_d    = alu_data;
            illegal_d = alu_illegal;
            if (gnt_id == ReqId0) begin
                if (cnt0_q != CntMax) cnt0_d = cnt0_q + 1'b1;
            end else begin
                if (cnt1_q != CntMax) cnt1_d = cnt1_q + 1'b1;
            end
        end else if (rsp_hs) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            last_q    <= ReqId1;
            owner_q   <= ReqId0;
            data_q    <= '0;
            illegal_q <= 1'b0;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            data_q    <= data_d;
            illegal_q <= illegal_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
        end
    end

    assign rsp_data_o    = data_q;
    assign rsp_illegal_o = illegal_q;
    assign grant0_cnt_o  = cnt0_q;
    assign grant1_cnt_o  = cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
// A second instance with CNT_W=2 shares the stimulus to cover saturation.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp0_ready, rsp1_ready;

    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_illegal;
    logic [31:0] rsp_data;
    logic [15:0] grant0_cnt, grant1_cnt;

    logic        s_req0_ready, s_req1_ready, s_rsp0_valid, s_rsp1_valid, s_rsp_illegal;
    logic [31:0] s_rsp_data;
    logic [1:0]  s_grant0_cnt, s_grant1_cnt;

    int n_chk = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
        .req0_a_i(req0_a), .req0_b_i(req0_b), .req0_op_i(req0_op),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
        .req1_a_i(req1_a), .req1_b_i(req1_b), .req1_op_i(req1_op),
        .rsp0_valid_o(rsp0_valid), .rsp0_ready_i(rsp0_ready),
        .rsp1_valid_o(rsp1_valid), .rsp1_ready_i(rsp1_ready),
        .rsp_data_o(rsp_data), .rsp_illegal_o(rsp_illegal),
        .grant0_cnt_o(grant0_cnt), .grant1_cnt_o(grant1_cnt)
    );

    alu_arbiter #(.CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_valid_i(req0_valid), .req0_ready_o(s_req0_ready),
        .req0_a_i(req0_a), .req0_b_i(req0_b), .req0_op_i(req0_op),
        .req1_valid_i(req1_valid), .req1_ready_o(s_req1_ready),
        .req1_a_i(req1_a), .req1_b_i(req1_b), .req1_op_i(req1_op),
        .rsp0_valid_o(s_rsp0_valid), .rsp0_ready_i(rsp0_ready),
        .rsp1_valid_o(s_rsp1_valid), .rsp1_ready_i(rsp1_ready),
        .rsp_data_o(s_rsp_data), .rsp_illegal_o(s_rsp_illegal),
        .grant0_cnt_o(s_grant0_cnt), .grant1_cnt_o(s_grant1_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU from the opcode table; returns {illegal, data}.
    function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        int sh;
        sh = int'(b[4:0]);
        case (op)
            4'd0: return {1'b0, a + b};
            4'd1: return {1'b0, a - b};
            4'd2: return {1'b0, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0};
            4'd3: return {1'b0, (a < b) ? 32'd1 : 32'd0};
            4'd4: return {1'b0, a ^ b};
            4'd5: return {1'b0, a | b};
            4'd6: return {1'b0, a & b};
            4'd7: return {1'b0, a << sh};
            4'd8: return {1'b0, a >> sh};
            4'd9: begin
                r = a >> sh;
                if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
                return {1'b0, r};
            end
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    // -1: nobody, else the requester that gets ready when idle.
    function automatic int winner(input logic v0, input logic v1, input int last);
        if (v0 && v1) return (last == 0) ? 1 : 0;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    // Model state: one held result or none.
    bit          m_busy;
    int          m_owner, m_last, m_cnt0, m_cnt1;
    logic [31:0] m_data;
    logic        m_ill;
    int          cur_win;
    logic [32:0] cur_res;

    always_comb cur_win = winner(req0_valid, req1_valid, m_last);
    assign cur_res = (cur_win == 1) ? ref_alu(req1_op, req1_a, req1_b)
                                    : ref_alu(req0_op, req0_a, req0_b);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_owner <= 0; m_last <= 1;
            m_data <= 32'd0; m_ill <= 1'b0; m_cnt0 <= 0; m_cnt1 <= 0;
        end else if (m_busy) begin
            if ((m_owner == 0) ? rsp0_ready : rsp1_ready) m_busy <= 1'b0;
        end else if (cur_win >= 0) begin
            m_busy  <= 1'b1;
            m_owner <= cur_win;
            m_last  <= cur_win;
            m_data  <= cur_res[31:0];
            m_ill   <= cur_res[32];
            if (cur_win == 0) m_cnt0 <= m_cnt0 + 1;
            else m_cnt1 <= m_cnt1 + 1;
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (check_en) begin
            logic e_r0, e_r1, e_v0, e_v1;
            e_r0 = rst_n && !m_busy && cur_win == 0;
            e_r1 = rst_n && !m_busy && cur_win == 1;
            e_v0 = m_busy && m_owner == 0;
            e_v1 = m_busy && m_owner == 1;
            chk("req0_ready", 32'(req0_ready), 32'(e_r0));
            chk("req1_ready", 32'(req1_ready), 32'(e_r1));
            chk("rsp0_valid", 32'(rsp0_valid), 32'(e_v0));
            chk("rsp1_valid", 32'(rsp1_valid), 32'(e_v1));
            chk("rsp_data", rsp_data, m_data);
            chk("rsp_illegal", 32'(rsp_illegal), 32'(m_ill));
            chk("grant0_cnt", 32'(grant0_cnt), 32'((m_cnt0 > 65535) ? 65535 : m_cnt0));
            chk("grant1_cnt", 32'(grant1_cnt), 32'((m_cnt1 > 65535) ? 65535 : m_cnt1));
            chk("sat_req0_ready", 32'(s_req0_ready), 32'(e_r0));
            chk("sat_req1_ready", 32'(s_req1_ready), 32'(e_r1));
            chk("sat_rsp0_valid", 32'(s_rsp0_valid), 32'(e_v0));
            chk("sat_rsp1_valid", 32'(s_rsp1_valid), 32'(e_v1));
            chk("sat_rsp_data", s_rsp_data, m_data);
            chk("sat_grant0_cnt", 32'(s_grant0_cnt), 32'((m_cnt0 > 3) ? 3 : m_cnt0));
            chk("sat_grant1_cnt", 32'(s_grant1_cnt), 32'((m_cnt1 > 3) ? 3 : m_cnt1));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic clr();
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic set0(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    endtask

    task automatic set1(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        clr();
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        req0_valid = 1'b1;   // ready must stay low during reset
        cyc(); cyc(); cyc();
        check_en = 1'b1;
        @(negedge clk);
        chk("lit_reset_ready0", 32'(req0_ready), 32'd0);
        chk("lit_reset_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("lit_reset_data", rsp_data, 32'd0);
        cyc();
        rst_n = 1'b1;
        req0_valid = 1'b0;
        cyc();

        // Single requester add.
        set0(4'd0, 32'h1234_5678, 32'h0123_4567);
        cyc();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("lit_add_valid", 32'(rsp0_valid), 32'd1);
        chk("lit_add_data", rsp_data, 32'h1357_9BDF);
        chk("lit_add_illegal", 32'(rsp_illegal), 32'd0);
        chk("lit_add_cnt0", 32'(grant0_cnt), 32'd1);
        cyc();
        rsp0_ready = 1'b1;
        cyc();
        rsp0_ready = 1'b0;
        do_reset();
        cyc();

        // Contention at first idle: req0 first, then req1, then alternate.
        set0(4'd1, 32'h0123_4567, 32'h89AB_CDEF);
        set1(4'd3, 32'h0123_4567, 32'h89AB_CDEF);
        @(negedge clk);
        chk("lit_rr_first_ready0", 32'(req0_ready), 32'd1);
        chk("lit_rr_first_ready1", 32'(req1_ready), 32'd0);
        cyc();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("lit_sub_data", rsp_data, 32'h7777_7778);
        chk("lit_hold_ready1", 32'(req1_ready), 32'd0);
        cyc();
        rsp0_ready = 1'b1;
        cyc();
        rsp0_ready = 1'b0;
        @(negedge clk);
        chk("lit_rr_second_ready1", 32'(req1_ready), 32'd1);
        cyc();
        req1_valid = 1'b0;
        @(negedge clk);
        chk("lit_sltu_valid1", 32'(rsp1_valid), 32'd1);
        chk("lit_sltu_data", rsp_data, 32'h0000_0001);
        cyc();
        rsp1_ready = 1'b1;
        cyc();
        rsp1_ready = 1'b0;
        set0(4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        set1(4'd5, 32'h1111_0000, 32'h0000_2222);
        @(negedge clk);
        chk("lit_alt_ready0", 32'(req0_ready), 32'd1);
        cyc();
        req0_valid = 1'b0;
        rsp0_ready = 1'b1;
        cyc();
        rsp0_ready = 1'b0;
        req0_valid = 1'b1;
        @(negedge clk);
        chk("lit_alt_ready1", 32'(req1_ready), 32'd1);
        chk("lit_alt_ready0_lost", 32'(req0_ready), 32'd0);
        cyc();
        clr();
        rsp1_ready = 1'b1;
        cyc();
        clr();

        // Stalled sra response on requester 1 with requester 0 waiting.
        set1(4'd9, 32'h89AB_CDEF, 32'h89AB_CDEF);
        cyc();
        req1_valid = 1'b0;
        set0(4'd0, 32'h0000_0001, 32'h0000_0002);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("lit_sra_hold_data", rsp_data, 32'hFFFF_1357);
            chk("lit_sra_hold_ready0", 32'(req0_ready), 32'd0);
            cyc();
        end
        rsp1_ready = 1'b1;
        cyc();
        rsp1_ready = 1'b0;
        @(negedge clk);
        chk("lit_sra_release_ready0", 32'(req0_ready), 32'd1);
        cyc();
        req0_valid = 1'b0;
        rsp0_ready = 1'b1;
        cyc();
        rsp0_ready = 1'b0;

        // Reserved opcode.
        set0(4'hC, 32'hDEAD_BEEF, 32'h1234_5678);
        cyc();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("lit_illegal_data", rsp_data, 32'd0);
        chk("lit_illegal_flag", 32'(rsp_illegal), 32'd1);
        cyc();
        rsp0_ready = 1'b1;
        cyc();
        rsp0_ready = 1'b0;
        @(negedge clk);
        chk("lit_illegal_done", 32'(rsp0_valid), 32'd0);

        // Reset in the middle of a held result.
        cyc();
        set0(4'd0, 32'h0000_0005, 32'h0000_0006);
        cyc();
        req0_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("lit_midreset_valid", 32'(rsp0_valid), 32'd0);
        chk("lit_midreset_cnt0", 32'(grant0_cnt), 32'd0);
        chk("lit_midreset_data", rsp_data, 32'd0);
        cyc();
        rst_n = 1'b1;
        set0(4'd6, 32'hFFFF_0000, 32'h00FF_FF00);
        set1(4'd7, 32'h0000_0001, 32'h0000_001F);
        @(negedge clk);
        chk("lit_postreset_ready0", 32'(req0_ready), 32'd1);
        chk("lit_postreset_ready1", 32'(req1_ready), 32'd0);
        cyc();
        clr();
        rsp0_ready = 1'b1;
        cyc();
        clr();

        // Five more requester-0 operations; narrow counter pins at 3.
        for (int i = 0; i < 5; i++) begin
            set0(4'($urandom_range(0, 9)), $urandom, $urandom);
            cyc();
            req0_valid = 1'b0;
            rsp0_ready = 1'b1;
            cyc();
            rsp0_ready = 1'b0;
        end
        @(negedge clk);
        chk("lit_sat_cnt0", 32'(s_grant0_cnt), 32'd3);
        chk("lit_wide_cnt0", 32'(grant0_cnt), 32'd6);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cyc();
            rst_n = ($urandom_range(0, 299) != 0);
            req0_valid = ($urandom_range(0, 99) < 60);
            req1_valid = ($urandom_range(0, 99) < 60);
            req0_op = 4'($urandom_range(0, 15));
            req1_op = 4'($urandom_range(0, 15));
            req0_a = $urandom;
            req1_a = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            req0_b = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            req1_b = $urandom;
            rsp0_ready = ($urandom_range(0, 99) < 50);
            rsp1_ready = ($urandom_range(0, 99) < 50);
        end
        cyc();
        rst_n = 1'b1;
        clr();
        cyc();
        @(negedge clk);
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter CNT_W, default 16: width of each per-requester grant counter.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 req0_valid_i / req1_valid_i  input  1 each  requester N presents an operation.
REQ-005 req0_ready_o / req1_ready_o  output  1 each  arbiter accepts requester N's operation this cycle.
REQ-006 req0_a_i, req0_b_i / req1_a_i, req1_b_i  input  32 each  operand_a / operand_b for requester N.
REQ-007 req0_op_i / req1_op_i  input  4 each  ALU opcode for requester N.
REQ-008 rsp0_valid_o / rsp1_valid_o  output  1 each  result for requester N is available.
REQ-009 rsp0_ready_i / rsp1_ready_i  input  1 each  requester N consumes its result.
REQ-010 rsp_data_o  output  32  registered ALU result, shared by both response channels.
REQ-011 rsp_illegal_o  output  1  registered opcode was 0xA-0xF.
REQ-012 grant0_cnt_o / grant1_cnt_o  output  CNT_W each  saturating count of accepted operations per requester.

Function
REQ-013 FSM states: IDLE (no result held) and HOLD (one result held); exactly one operation is outstanding at a time.
REQ-014 In IDLE with one valid requester, that requester's ready_o is 1 and the other's ready_o is 0.
REQ-015 In IDLE with both requesters valid, ready_o goes only to the requester not granted last (round-robin).
REQ-016 In HOLD, both req ready_o are 0.
REQ-017 A transfer occurs when valid_i and ready_o are both 1; on that edge the FSM moves IDLE->HOLD.
REQ-018 On the transfer edge, the arbiter registers the alu output for the granted operands/opcode into rsp_data_o, the requester id, and rsp_illegal_o.
REQ-019 Latency from transfer edge to rsp valid is 1 cycle.
REQ-020 In HOLD, only the granted requester's rsp valid is 1.
REQ-021 rsp_data_o and rsp_illegal_o stay stable in HOLD until that requester's rsp ready_i is 1; the FSM then returns HOLD->IDLE on that edge.
REQ-022 No new grant occurs in the same cycle as the response handshake, so back-to-back throughput is one operation per 2 cycles.
REQ-023 rsp ready_i from the non-granted requester is ignored.
REQ-024 Opcodes: 0 add, 1 sub, 2 slt (signed), 3 sltu, 4 xor, 5 or, 6 and, 7 sll, 8 srl, 9 sra, all 32-bit wrap-around; shift amount is b[4:0].
REQ-025 Opcodes 0xA-0xF produce rsp_data_o=0 and rsp_illegal_o=1 and are still answered normally.
REQ-026 On each transfer, the winner's grant counter increments by 1 and saturates at all-ones.
REQ-027 The last-grant pointer updates only on a transfer.
REQ-028 Request inputs need not be held after the transfer edge.

Reset
REQ-029 Asserting rst_ni low immediately forces: FSM=IDLE, rsp0/rsp1 valid=0, rsp_data_o=0, rsp_illegal_o=0, counters=0, last-grant pointer=1 (requester 0 wins first contention).
REQ-030 A held result is discarded on reset mid-operation; it is never presented after reset release.
REQ-031 req ready_o is 0 while rst_ni is low.

Structure
REQ-032 The opcode enumeration (ALU_ADD..ALU_SRA, 4-bit) and the requester-id type belong in the shared pipeline package, used by both alu and alu_arbiter.
REQ-033 The existing combinational alu (operand_a, operand_b, alu_op -> alu_data) is instantiated once as the only sub-module; the arbiter drives its inputs from a combinational grant mux.

Verification
REQ-034 Req0 only: a=0x12345678, b=0x01234567, op=0 -> 1 cycle later rsp0 valid=1, data=0x13579BDF, illegal=0, grant0_cnt=1.
REQ-035 Both valid at first IDLE: req0 sub 0x01234567-0x89ABCDEF; req1 sltu with the same operands -> req0 served first with 0x77777778; after rsp0 handshake, req1 served with 0x00000001; contention alternates thereafter.
REQ-036 rsp1_ready_i held 0 for 5 cycles on sra a=0x89ABCDEF, b=0x89ABCDEF -> data holds 0xFFFF1357, no new grant; release ready -> IDLE next cycle.
REQ-037 op=0xC -> data=0, illegal=1, response handshake completes normally.
REQ-038 rst_ni pulsed low while in HOLD -> rsp valid=0 asynchronously, counters=0; after release, first contention grants req0.
REQ-039 CNT_W=2 override with 5 req0 operations -> grant0_cnt saturates at 3.
